matmul_output_control: RTL and testbench
========================================

Name: matmul_output_control

Overview:
- Collects the bottom-of-array results of the weight-stationary systolic array, one column at a time, into a ROWS x COLS output matrix.
- When a column's proxy (spare) PE reports valid data, the proxy word replaces that column's array output.
- On request from the matmul FSM, writes the finished matrix to output RAM as packed words, stalling the datapath while writing.
- Sits between systolic_matmul_fsm / stw_wproxy_systolic and the output memory port.

Parameters:
ROWS, 4, array rows = output matrix rows
COLS, 4, array columns = output matrix columns
WORD_SIZE, 16, bits per matrix element
MEM_ACCESS_LATENCY, 1, cycles per memory write beat (>=1)
MEM_PORT_WIDTH, 32, memory data width; integer multiple of WORD_SIZE

Ports:
clk  in  1  clock; single clock domain
rst  in  1  reset; synchronous, active-low
stall  out  1  freezes matmul FSM and array while high
fsm_rdy  in  1  FSM idle/ready for a new matmul; clears capture counters
fsm_done  in  1  matmul finished; capture disabled until next fsm_rdy
matmul_fsm_output  in  COLS*WORD_SIZE  bottom_out words; column c at [c*WORD_SIZE +: WORD_SIZE]
matmul_output_valid  in  COLS  bit c = column c output valid this cycle
proxy_output_bus  in  COLS*WORD_SIZE  proxy outputs, same packing
proxy_out_valid_bus  in  COLS  bit c = proxy of column c valid
output_matrix  out  [ROWS][COLS] x WORD_SIZE  captured result matrix
wr_output_rdy  in  1  pulse: matrix complete, start write-out
wr_output_done  out  1  one-cycle pulse when write-out finishes
mem_addr  out  32  output RAM beat address
mem_wr_en  out  1  output RAM write strobe
mem_data  out  MEM_PORT_WIDTH  output RAM write data

Behaviour:
- Reset (rst==0 at a clk edge): output_matrix all 0, all row counters 0, state IDLE, stall=0, mem_wr_en=0, mem_addr=0, mem_data=0, wr_output_done=0.
- Capture:
  - Per-column row counter row[c], range 0..ROWS.
  - Capture is enabled when stall==0, fsm_done==0 and state==IDLE.
  - On a clk edge with capture enabled, for each c with matmul_output_valid[c]==1 and row[c]<ROWS:
    - output_matrix[row[c]][c] <= proxy_out_valid_bus[c] ? proxy word c : matmul word c.
    - row[c] increments.
  - Valid asserted when row[c]==ROWS is ignored (no wrap).
  - fsm_rdy==1 clears all row[c] to 0; output_matrix keeps its contents.
  - fsm_rdy has priority over a simultaneous capture.
- Write-out FSM: IDLE -> WRITE -> WAIT -> (WRITE | DONE) -> IDLE.
  - IDLE: wr_output_rdy==1 -> WRITE with beat index b=0. Otherwise stall=0.
  - W = MEM_PORT_WIDTH/WORD_SIZE. NBEATS = ceil(ROWS*COLS/W).
  - Matrix is flattened row-major: element i = output_matrix[i/COLS][i%COLS].
  - WRITE: mem_wr_en=1 for exactly one cycle; mem_addr=b.
    - mem_data word k (bits [k*WORD_SIZE +: WORD_SIZE]) = element b*W+k.
    - Slots past the last element are zero-padded.
  - WAIT: mem_wr_en=0 for MEM_ACCESS_LATENCY-1 cycles (skipped when latency is 1).
    - Then, if b<NBEATS-1: b++ and go to WRITE; else go to DONE.
  - DONE: wr_output_done=1 for one cycle, then IDLE.
  - stall=1 in WRITE, WAIT and DONE; 0 in IDLE.
  - mem_addr/mem_data hold their last values when mem_wr_en=0.
- Latency: first write occurs the cycle after wr_output_rdy is sampled. With latency 1 the beats are back-to-back; wr_output_done comes 1 cycle after the last beat.
- wr_output_rdy outside IDLE is ignored. Capture inputs are ignored outside IDLE.
- Reset mid-write aborts: no wr_output_done, stall drops on the next cycle.
- Combinational paths: none from inputs to outputs; all outputs registered.

Test Plan:
- Reset: hold rst=0 for 2 cycles with random inputs -> output_matrix all 0, stall=0, mem_wr_en=0, wr_output_done=0.
- Capture, defaults: fsm_rdy pulse, then 4 cycles with all matmul_output_valid=4'hF and word(c)=0x10*r+c on cycle r -> output_matrix[r][c]=0x10*r+c. A fifth valid cycle leaves the matrix unchanged.
- Proxy override: column 2 with proxy_out_valid_bus[2]=1 and proxy word 0xBEEF on every valid cycle -> column 2 all 0xBEEF; other columns hold array values.
- Staggered columns: col0 valid on cycles 0-3, col3 valid on cycles 3-6 -> each column gets its 4 words in arrival order.
- Write-out, latency 1, 32-bit port: wr_output_rdy pulse -> 8 consecutive beats, mem_addr 0..7.
  - Beat 0 mem_data = {m[0][1], m[0][0]}.
  - stall=1 throughout.
  - wr_output_done pulses 1 cycle after beat 7.
  - stall=0 the following cycle.
- Latency 3 and ROWS=COLS=3 with 32-bit port: 5 beats spaced 3 cycles apart; beat 4 upper half = 0. Reset asserted during beat 2 -> no further beats, no done pulse.

Source files
------------

// File: rtl/matmul_output_control.sv
// Output collector for the weight-stationary systolic array: captures
// column results (with proxy override) into a ROWS x COLS matrix and
// streams the finished matrix to output RAM as packed beats.
//
// Ports:
//   clk, rst (sync, active-low)
//   fsm_rdy / fsm_done         : capture window control from matmul FSM
//   matmul_fsm_output / _valid : bottom-of-array words per column
//   proxy_output_bus / _valid  : spare-PE words, override when valid
//   output_matrix              : captured result matrix
//   wr_output_rdy / _done      : write-out request / completion pulse
//   mem_addr/mem_wr_en/mem_data: output RAM write port
//   stall                      : freezes FSM and array during write-out
module matmul_output_control #(
    parameter int ROWS               = 4,
    parameter int COLS               = 4,
    parameter int WORD_SIZE          = 16,
    parameter int MEM_ACCESS_LATENCY = 1,
    parameter int MEM_PORT_WIDTH     = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          stall,
    input  logic                          fsm_rdy,
    input  logic                          fsm_done,
    input  logic [COLS*WORD_SIZE-1:0]     matmul_fsm_output,
    input  logic [COLS-1:0]               matmul_output_valid,
    input  logic [COLS*WORD_SIZE-1:0]     proxy_output_bus,
    input  logic [COLS-1:0]               proxy_out_valid_bus,
    output logic [WORD_SIZE-1:0]          output_matrix [ROWS][COLS],
    input  logic                          wr_output_rdy,
    output logic                          wr_output_done,
    output logic [31:0]                   mem_addr,
    output logic                          mem_wr_en,
    output logic [MEM_PORT_WIDTH-1:0]     mem_data
);

    localparam int W      = MEM_PORT_WIDTH / WORD_SIZE;
    localparam int NELEM  = ROWS * COLS;
    localparam int NBEATS = (NELEM + W - 1) / W;
    localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int RW     = $clog2(ROWS + 1);
    localparam int CW     = (MEM_ACCESS_LATENCY > 1) ?
                            $clog2(MEM_ACCESS_LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                      r_state;
    state_t                      w_next;
    logic [BW-1:0]               r_beat;
    logic [BW-1:0]               w_next_beat;
    logic [CW-1:0]               r_wcnt;
    logic [RW-1:0]               r_row [COLS];
    logic [WORD_SIZE-1:0]        r_mat [ROWS][COLS];
    logic [31:0]                 r_mem_addr;
    logic [MEM_PORT_WIDTH-1:0]   r_mem_data;
    logic [NBEATS*MEM_PORT_WIDTH-1:0] w_flat;
    logic                        w_cap_en;
    logic                        w_last;
    logic                        w_adv;

    assign w_cap_en = (r_state == S_IDLE) && !fsm_done;
    assign w_last   = (int'(r_beat) == NBEATS - 1);

    // Leave WRITE/WAIT for the next beat once the beat has occupied
    // MEM_ACCESS_LATENCY cycles in total.
    assign w_adv = ((r_state == S_WRITE) && (MEM_ACCESS_LATENCY == 1)) ||
                   ((r_state == S_WAIT) &&
                    (int'(r_wcnt) == MEM_ACCESS_LATENCY - 2));

    // Row-major flattening, zero-padded to a whole number of beats.
    always_comb begin
        w_flat = '0;
        for (int i = 0; i < NELEM; i++) begin
            w_flat[i*WORD_SIZE +: WORD_SIZE] = r_mat[i/COLS][i%COLS];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_beat     <= '0;
            r_wcnt     <= '0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
        end else begin
            r_state <= w_next;
            r_beat  <= w_next_beat;
            if (r_state != S_WAIT) begin
                r_wcnt <= '0;
            end else begin
                r_wcnt <= r_wcnt + CW'(1);
            end
            // Address/data are loaded as WRITE is entered so the
            // strobe and its payload appear in the same cycle.
            if (w_next == S_WRITE) begin
                r_mem_addr <= 32'(w_next_beat);
                r_mem_data <=
                    w_flat[w_next_beat*MEM_PORT_WIDTH +: MEM_PORT_WIDTH];
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        w_next_beat = r_beat;
        unique case (r_state)
            S_IDLE: begin
                if (wr_output_rdy) begin
                    w_next      = S_WRITE;
                    w_next_beat = '0;
                end
            end
            S_WRITE, S_WAIT: begin
                if (w_adv) begin
                    if (w_last) begin
                        w_next = S_DONE;
                    end else begin
                        w_next      = S_WRITE;
                        w_next_beat = r_beat + BW'(1);
                    end
                end else if (r_state == S_WRITE) begin
                    w_next = S_WAIT;
                end
            end
            S_DONE: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        stall          = (r_state != S_IDLE);
        mem_wr_en      = (r_state == S_WRITE);
        wr_output_done = (r_state == S_DONE);
    end

    assign mem_addr = r_mem_addr;
    assign mem_data = r_mem_data;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int c = 0; c < COLS; c++) begin
                r_row[c] <= '0;
                for (int r = 0; r < ROWS; r++) begin
                    r_mat[r][c] <= '0;
                end
            end
        end else if (fsm_rdy) begin
            for (int c = 0; c < COLS; c++) begin
                r_row[c] <= '0;
            end
        end else if (w_cap_en) begin
            for (int c = 0; c < COLS; c++) begin
                if (matmul_output_valid[c] && (r_row[c] < RW'(ROWS))) begin
                    for (int r = 0; r < ROWS; r++) begin
                        if (r_row[c] == RW'(r)) begin
                            r_mat[r][c] <= proxy_out_valid_bus[c] ?
                                proxy_output_bus[c*WORD_SIZE +: WORD_SIZE] :
                                matmul_fsm_output[c*WORD_SIZE +: WORD_SIZE];
                        end
                    end
                    r_row[c] <= r_row[c] + RW'(1);
                end
            end
        end
    end

    assign output_matrix = r_mat;

endmodule

// File: tb/tb_matmul_output_control.sv
// Self-checking bench for matmul_output_control: default 4x4/latency-1
// instance plus a 3x3/latency-3 instance for spaced beats and abort.
module tb_matmul_output_control;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Default instance
    logic        rst, fsm_rdy, fsm_done, wr_rdy;
    logic [63:0] mo, po;
    logic [3:0]  mv, pv;
    logic [15:0] om [4][4];
    logic        stall, done, we;
    logic [31:0] addr, data;

    // 3x3, latency 3 instance
    logic        rst3, fsm_rdy3, fsm_done3, wr_rdy3;
    logic [47:0] mo3, po3;
    logic [2:0]  mv3, pv3;
    logic [15:0] om3 [3][3];
    logic        stall3, done3, we3;
    logic [31:0] addr3, data3;

    matmul_output_control dut (
        .clk(clk), .rst(rst), .stall(stall),
        .fsm_rdy(fsm_rdy), .fsm_done(fsm_done),
        .matmul_fsm_output(mo), .matmul_output_valid(mv),
        .proxy_output_bus(po), .proxy_out_valid_bus(pv),
        .output_matrix(om), .wr_output_rdy(wr_rdy),
        .wr_output_done(done), .mem_addr(addr),
        .mem_wr_en(we), .mem_data(data)
    );

    matmul_output_control #(
        .ROWS(3), .COLS(3), .WORD_SIZE(16),
        .MEM_ACCESS_LATENCY(3), .MEM_PORT_WIDTH(32)
    ) dut3 (
        .clk(clk), .rst(rst3), .stall(stall3),
        .fsm_rdy(fsm_rdy3), .fsm_done(fsm_done3),
        .matmul_fsm_output(mo3), .matmul_output_valid(mv3),
        .proxy_output_bus(po3), .proxy_out_valid_bus(pv3),
        .output_matrix(om3), .wr_output_rdy(wr_rdy3),
        .wr_output_done(done3), .mem_addr(addr3),
        .mem_wr_en(we3), .mem_data(data3)
    );

    // Reference model: expected matrix and per-column fill level.
    logic [15:0] em [4][4];
    int          erow [4];
    logic [15:0] em3 [3][3];

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic model_step(input logic [3:0] v, input logic [63:0] w,
                              input logic [3:0] p, input logic [63:0] pw,
                              input logic rdy, input logic dn);
        if (rdy) begin
            for (int c = 0; c < 4; c++) erow[c] = 0;
        end else if (!dn) begin
            for (int c = 0; c < 4; c++) begin
                if (v[c] && erow[c] < 4) begin
                    em[erow[c]][c] = p[c] ? pw[c*16 +: 16] : w[c*16 +: 16];
                    erow[c]++;
                end
            end
        end
    endtask

    task automatic cap_cycle(input logic [3:0] v, input logic [63:0] w,
                             input logic [3:0] p, input logic [63:0] pw,
                             input logic rdy, input logic dn);
        mv = v; mo = w; pv = p; po = pw; fsm_rdy = rdy; fsm_done = dn;
        @(posedge clk);
        model_step(v, w, p, pw, rdy, dn);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; rst3 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mv = 4'($urandom); mo = rnd64(); pv = 4'($urandom); po = rnd64();
            fsm_rdy = 1'($urandom); fsm_done = 1'($urandom); wr_rdy = 1'b1;
            mv3 = 3'($urandom); mo3 = 48'(rnd64()); pv3 = 3'($urandom);
            po3 = 48'(rnd64()); fsm_rdy3 = 1'b0; fsm_done3 = 1'b0;
            wr_rdy3 = 1'b1;
            @(posedge clk); #1;
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                em[r][c] = '0;
                checks++;
                if (om[r][c] !== 16'h0) begin
                    errors++;
                    $display("FAIL reset_matrix r%0d c%0d got %h exp 0",
                             r, c, om[r][c]);
                end
            end
        for (int c = 0; c < 4; c++) erow[c] = 0;
        checks++;
        if ({stall, we, done, addr, data} !== 67'h0) begin
            errors++;
            $display("FAIL reset_outs got st%b we%b dn%b a%h d%h exp 0",
                     stall, we, done, addr, data);
        end
        checks++;
        if ({stall3, we3, done3} !== 3'b000) begin
            errors++;
            $display("FAIL reset_outs3 got %b exp 000",
                     {stall3, we3, done3});
        end
        rst = 1'b1; rst3 = 1'b1;
        wr_rdy = 1'b0; wr_rdy3 = 1'b0;
        mv = '0; pv = '0; fsm_rdy = 1'b0; fsm_done = 1'b0;
        mv3 = '0; pv3 = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_capture();
        logic [63:0] w;
        // fsm_rdy wins over a simultaneous valid
        cap_cycle(4'hF, rnd64(), 4'h0, rnd64(), 1'b1, 1'b0);
        for (int r = 0; r < 5; r++) begin
            w = '0;
            for (int c = 0; c < 4; c++)
                w[c*16 +: 16] = (r < 4) ? 16'(16*r + c) : 16'($urandom);
            cap_cycle(4'hF, w, 4'h0, rnd64(), 1'b0, 1'b0);
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (om[r][c] !== 16'(16*r + c) || om[r][c] !== em[r][c]) begin
                    errors++;
                    $display("FAIL capture r%0d c%0d got %h exp %h",
                             r, c, om[r][c], 16'(16*r + c));
                end
            end
    endtask

    task automatic test_proxy();
        logic [63:0] pw;
        cap_cycle(4'h0, '0, 4'h0, '0, 1'b1, 1'b0);
        for (int r = 0; r < 4; r++) begin
            pw = rnd64();
            pw[32 +: 16] = 16'hBEEF;
            cap_cycle(4'hF, rnd64(), 4'b0100, pw, 1'b0, 1'b0);
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (om[r][c] !== em[r][c] ||
                    (c == 2 && om[r][c] !== 16'hBEEF)) begin
                    errors++;
                    $display("FAIL proxy r%0d c%0d got %h exp %h",
                             r, c, om[r][c], em[r][c]);
                end
            end
    endtask

    task automatic test_staggered();
        logic [3:0] v;
        cap_cycle(4'h0, '0, 4'h0, '0, 1'b1, 1'b0);
        for (int t = 0; t < 7; t++) begin
            v = 4'h0;
            v[0] = (t <= 3);
            v[3] = (t >= 3);
            cap_cycle(v, rnd64(), 4'h0, rnd64(), 1'b0, 1'b0);
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (om[r][c] !== em[r][c]) begin
                    errors++;
                    $display("FAIL stagger r%0d c%0d got %h exp %h",
                             r, c, om[r][c], em[r][c]);
                end
            end
    endtask

    task automatic test_random();
        for (int t = 0; t < 24; t++) begin
            cap_cycle(4'($urandom), rnd64(), 4'($urandom & $urandom),
                      rnd64(), ($urandom_range(0, 7) == 0),
                      ($urandom_range(0, 5) == 0));
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    checks++;
                    if (om[r][c] !== em[r][c]) begin
                        errors++;
                        $display("FAIL random t%0d r%0d c%0d got %h exp %h",
                                 t, r, c, om[r][c], em[r][c]);
                    end
                end
        end
    endtask

    task automatic test_write();
        logic [31:0] exp;
        int          i;
        cap_cycle(4'h0, '0, 4'h0, '0, 1'b1, 1'b0);
        for (int r = 0; r < 4; r++)
            cap_cycle(4'hF, rnd64(), 4'h0, '0, 1'b0, 1'b0);
        // re-arm counters so stray valids during write would land
        cap_cycle(4'h0, '0, 4'h0, '0, 1'b1, 1'b0);
        wr_rdy = 1'b1;
        @(posedge clk); #1;
        wr_rdy = 1'b0;
        for (int t = 1; t <= 10; t++) begin
            if (t <= 8) begin
                exp = '0;
                for (int k = 0; k < 2; k++) begin
                    i = (t - 1) * 2 + k;
                    exp[k*16 +: 16] = em[i/4][i%4];
                end
                checks++;
                if (we !== 1'b1 || addr !== 32'(t - 1) || data !== exp ||
                    stall !== 1'b1 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL beat%0d got we%b a%0d d%h st%b exp a%0d d%h",
                             t - 1, we, addr, data, stall, t - 1, exp);
                end
            end else begin
                checks++;
                if (we !== 1'b0 || done !== (t == 9) ||
                    stall !== (t == 9)) begin
                    errors++;
                    $display("FAIL wr_tail t%0d got we%b dn%b st%b",
                             t, we, done, stall);
                end
            end
            mv = 4'($urandom); mo = rnd64(); pv = 4'($urandom);
            wr_rdy = (t == 3);
            @(posedge clk); #1;
        end
        mv = '0; wr_rdy = 1'b0;
        checks++;
        if (we !== 1'b0 || stall !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL wr_ignore got we%b st%b dn%b exp 000",
                     we, stall, done);
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (om[r][c] !== em[r][c]) begin
                    errors++;
                    $display("FAIL wr_hold r%0d c%0d got %h exp %h",
                             r, c, om[r][c], em[r][c]);
                end
            end
        cap_cycle(4'hF, rnd64(), 4'h0, '0, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (om[0][c] !== em[0][c]) begin
                errors++;
                $display("FAIL post_wr c%0d got %h exp %h",
                         c, om[0][c], em[0][c]);
            end
        end
        mv = '0;
    endtask

    task automatic fill3();
        fsm_rdy3 = 1'b1;
        @(posedge clk); #1;
        fsm_rdy3 = 1'b0;
        for (int r = 0; r < 3; r++) begin
            mv3 = 3'b111; mo3 = 48'(rnd64());
            for (int c = 0; c < 3; c++) em3[r][c] = mo3[c*16 +: 16];
            @(posedge clk); #1;
        end
        mv3 = '0;
    endtask

    task automatic test_lat3();
        logic [31:0] exp;
        int          i;
        fill3();
        wr_rdy3 = 1'b1;
        @(posedge clk); #1;
        wr_rdy3 = 1'b0;
        for (int t = 1; t <= 18; t++) begin
            checks++;
            if (we3 !== ((t % 3 == 1) && t <= 13) || done3 !== (t == 16) ||
                stall3 !== (t <= 16)) begin
                errors++;
                $display("FAIL lat3_ctl t%0d got we%b dn%b st%b",
                         t, we3, done3, stall3);
            end
            if ((t % 3 == 1) && t <= 13) begin
                exp = '0;
                for (int k = 0; k < 2; k++) begin
                    i = ((t - 1) / 3) * 2 + k;
                    if (i < 9) exp[k*16 +: 16] = em3[i/3][i%3];
                end
                checks++;
                if (addr3 !== 32'((t - 1) / 3) || data3 !== exp) begin
                    errors++;
                    $display("FAIL lat3_beat t%0d got a%0d d%h exp a%0d d%h",
                             t, addr3, data3, (t - 1) / 3, exp);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_abort();
        fill3();
        wr_rdy3 = 1'b1;
        @(posedge clk); #1;
        wr_rdy3 = 1'b0;
        for (int t = 1; t <= 7; t++) begin
            if (t < 7) begin
                @(posedge clk); #1;
            end
        end
        checks++;
        if (we3 !== 1'b1 || addr3 !== 32'd2) begin
            errors++;
            $display("FAIL abort_beat2 got we%b a%0d exp we1 a2", we3, addr3);
        end
        rst3 = 1'b0;
        @(posedge clk); #1;
        rst3 = 1'b1;
        for (int t = 8; t <= 22; t++) begin
            checks++;
            if (we3 !== 1'b0 || done3 !== 1'b0 || stall3 !== 1'b0) begin
                errors++;
                $display("FAIL abort t%0d got we%b dn%b st%b exp 000",
                         t, we3, done3, stall3);
            end
            @(posedge clk); #1;
        end
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                checks++;
                if (om3[r][c] !== 16'h0) begin
                    errors++;
                    $display("FAIL abort_mat r%0d c%0d got %h exp 0",
                             r, c, om3[r][c]);
                end
            end
    endtask

    initial begin
        rst = 1'b0; rst3 = 1'b0;
        fsm_rdy = 1'b0; fsm_done = 1'b0; wr_rdy = 1'b0;
        mo = '0; po = '0; mv = '0; pv = '0;
        fsm_rdy3 = 1'b0; fsm_done3 = 1'b0; wr_rdy3 = 1'b0;
        mo3 = '0; po3 = '0; mv3 = '0; pv3 = '0;
        #1;
        test_reset();
        test_capture();
        test_proxy();
        test_staggered();
        test_random();
        test_write();
        test_lat3();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
